// File: rtl/tcdm_init_master_pkg.sv
// tcdm_init_pkg: FSM states, word-to-byte shift and expected-pattern helper for tcdm_init_master.
package tcdm_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int unsigned WORD_SHIFT = 2;

    function automatic logic [63:0] exp_word(input logic [63:0] pattern, input logic [63:0] idx);
        return pattern ^ idx;
    endfunction

endpackage

// File: rtl/tcdm_init_master_if.sv
// hci_mem_intf: TCDM request/response bus with master and slave modports.
interface hci_mem_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 1
);
    logic            req;
    logic            gnt;
    logic            wen;
    logic [AW-1:0]   add;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [IW-1:0]   id;
    logic [DW-1:0]   r_data;
    logic [IW-1:0]   r_id;

    modport master(output req, add, wen, data, be, id, input gnt, r_data, r_id);
    modport slave(input req, add, wen, data, be, id, output gnt, r_data, r_id);
endinterface

// File: rtl/tcdm_init_master.sv
// tcdm_init_master: writes pattern^idx over a TCDM bank, optionally reads it back and checks it.
// Readback verification is built only when TCDM_INIT_READBACK_EN is defined.
module tcdm_init_master
    import tcdm_init_pkg::*;
#(
    parameter int unsigned     NbWords   = 256,
    parameter int unsigned     DataWidth = 32,
    parameter int unsigned     AddrWidth = 32,
    parameter int unsigned     IdWidth   = 1,
    parameter longint unsigned BaseAddr  = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [DataWidth-1:0]           pattern_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic [AddrWidth-1:0]           err_addr_o,
    output logic [$clog2(NbWords+1)-1:0]   err_count_o,
    hci_mem_intf.master                    tcdm_master
);
    localparam int unsigned     IdxW    = NbWords > 1 ? $clog2(NbWords) : 1;
    localparam int unsigned     CntW    = $clog2(NbWords + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NbWords - 1);
`ifdef TCDM_INIT_READBACK_EN
    localparam bit ReadBack = 1'b1;
`else
    localparam bit ReadBack = 1'b0;
`endif

    state_e                r_state;
    state_e                w_next;
    logic [IdxW-1:0]       r_idx;
    logic [DataWidth-1:0]  r_pattern;
    logic                  w_start;
    logic                  w_req;
    logic                  w_hs;
    logic                  w_last;
    logic [AddrWidth-1:0]  w_add;
    logic [DataWidth-1:0]  w_exp;

    assign w_start = start_i && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_req   = r_state == ST_WRITE || r_state == ST_READ;
    assign w_hs    = w_req && tcdm_master.gnt;
    assign w_last  = r_idx == LastIdx;
    assign w_add   = AddrWidth'(BaseAddr) + (AddrWidth'(r_idx) << WORD_SHIFT);
    assign w_exp   = DataWidth'(exp_word(64'(r_pattern), 64'(r_idx)));

    // Request fields derive only from state/idx, so they hold while gnt is low.
    assign tcdm_master.req  = w_req;
    assign tcdm_master.wen  = r_state != ST_WRITE;
    assign tcdm_master.add  = w_req ? w_add : '0;
    assign tcdm_master.data = r_state == ST_WRITE ? w_exp : '0;
    assign tcdm_master.be   = w_req ? '1 : '0;
    assign tcdm_master.id   = w_req ? IdWidth'(r_idx) : '0;

    assign busy_o = r_state == ST_WRITE || r_state == ST_READ || r_state == ST_DRAIN;
    assign done_o = r_state == ST_DONE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_pattern <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_idx     <= '0;
                r_pattern <= pattern_i;
            end else if (w_hs) begin
                r_idx <= w_last ? '0 : r_idx + IdxW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: w_next = w_start ? ST_WRITE : r_state;
            ST_WRITE:         w_next = (w_hs && w_last) ? (ReadBack ? ST_READ : ST_DONE) : ST_WRITE;
            ST_READ:          w_next = (w_hs && w_last) ? ST_DRAIN : ST_READ;
            ST_DRAIN:         w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

`ifdef TCDM_INIT_READBACK_EN
    logic                  r_chk;
    logic [DataWidth-1:0]  r_exp;
    logic [AddrWidth-1:0]  r_exp_add;
    logic                  r_error;
    logic [AddrWidth-1:0]  r_err_addr;
    logic [CntW-1:0]       r_err_cnt;
    logic                  w_mis;
    logic                  w_unused;

    // Bank latency is one cycle: the response lines up with the word registered at the handshake.
    assign w_mis    = r_chk && tcdm_master.r_data != r_exp;
    assign w_unused = ^tcdm_master.r_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_chk      <= 1'b0;
            r_exp      <= '0;
            r_exp_add  <= '0;
            r_error    <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_chk <= w_hs && r_state == ST_READ;
            if (w_hs) begin
                r_exp     <= w_exp;
                r_exp_add <= w_add;
            end
            if (w_start) begin
                r_error    <= 1'b0;
                r_err_addr <= '0;
                r_err_cnt  <= '0;
            end else if (w_mis) begin
                r_error <= 1'b1;
                if (!r_error) r_err_addr <= r_exp_add;
                if (r_err_cnt != CntW'(NbWords)) r_err_cnt <= r_err_cnt + CntW'(1);
            end
        end
    end

    assign error_o     = r_error;
    assign err_addr_o  = r_err_addr;
    assign err_count_o = r_err_cnt;
`else
    logic w_unused;

    assign w_unused    = ^{tcdm_master.r_data, tcdm_master.r_id};
    assign error_o     = 1'b0;
    assign err_addr_o  = '0;
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_init_master.sv
// tb_tcdm_init_master: random-stall bank model plus transaction-level reference for tcdm_init_master.
// Expectations follow TCDM_INIT_READBACK_EN so the bench suits both builds.
module tb_tcdm_init_master;
    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef TCDM_INIT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int TOTAL = RB ? 2 * N : N;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pattern_i;
    logic        busy, done, error;
    logic [31:0] err_addr;
    logic [4:0]  err_count;

    hci_mem_intf #(.DW(32), .AW(32), .IW(1)) bus ();

    tcdm_init_master #(
        .NbWords(N), .DataWidth(32), .AddrWidth(32), .IdWidth(1), .BaseAddr(BASE)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pattern_i(pattern_i),
        .busy_o(busy), .done_o(done), .error_o(error), .err_addr_o(err_addr),
        .err_count_o(err_count), .tcdm_master(bus.master)
    );

    always #5 clk = ~clk;

    int          total_cnt = 0;
    int          bad_cnt = 0;
    int          mk = 0;
    int          rd_cnt = 0;
    int          k;
    bit          rd;
    bit          rand_gnt = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] cur_pat = '0;
    logic [31:0] snap_add, snap_data;
    logic        snap_wen, snap_id;
    logic [31:0] mem [N];
    bit          corrupt [N];
    logic [31:0] wa;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        bus.gnt = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Bank: writes land at the handshake edge, read data appears one cycle later.
    always @(posedge clk) begin
        if (bus.req && bus.gnt) begin
            wa = (bus.add - BASE) >> 2;
            if (!bus.wen) mem[wa[3:0]] <= bus.data;
            else bus.r_data <= mem[wa[3:0]] ^ (corrupt[wa[3:0]] ? 32'h0000_0100 : 32'h0);
            bus.r_id <= bus.id;
        end
    end

    // Reference: the sweep is the ordered list writes(0..N-1) then, with readback, reads(0..N-1).
    always @(negedge clk) begin
        if (rst_i) begin
            mk = 0;
            stalled = 1'b0;
        end else begin
            if (done) begin
                chk("done_no_req", bus.req, 0);
                chk("done_not_busy", busy, 0);
            end
            if (bus.req) begin
                k  = mk % N;
                rd = mk >= N;
                chk("req_within_sweep", mk < TOTAL, 1);
                chk("busy_with_req", busy, 1);
                chk("req_add", bus.add, BASE + 32'(4 * k));
                chk("req_wen", bus.wen, rd);
                chk("req_be", bus.be, 4'hF);
                chk("req_id", bus.id, k & 1);
                if (!rd) chk("req_data", bus.data, cur_pat ^ 32'(k));
                if (stalled) begin
                    chk("stall_add", bus.add, snap_add);
                    chk("stall_data", bus.data, snap_data);
                    chk("stall_wen", bus.wen, snap_wen);
                    chk("stall_id", bus.id, snap_id);
                end
                snap_add  = bus.add;
                snap_data = bus.data;
                snap_wen  = bus.wen;
                snap_id   = bus.id;
                stalled   = !bus.gnt;
                if (bus.gnt) begin
                    mk++;
                    if (rd) rd_cnt++;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic start_sweep(input logic [31:0] p);
        @(posedge clk);
        #1;
        start_i   = 1'b1;
        pattern_i = p;
        cur_pat   = p;
        mk        = 0;
        rd_cnt    = 0;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        pattern_i = $urandom;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("error_cleared", error, 0);
        chk("err_cnt_cleared", err_count, 0);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 1;
        while (!done && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic check_sweep(input logic [31:0] p, input logic e, input logic [31:0] ea, input int ec);
        for (int i = 0; i < N; i++) chk("bank_word", mem[i], p ^ 32'(i));
        chk("handshakes", mk, TOTAL);
        chk("read_requests", rd_cnt, RB ? N : 0);
        chk("error_o", error, e);
        chk("err_addr_o", err_addr, ea);
        chk("err_count_o", err_count, ec);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", bus.req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_wen", bus.wen, 1);
        chk("rst_add", bus.add, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_be", bus.be, 0);
        chk("rst_id", bus.id, 0);
    endtask

    initial begin
        int          n;
        logic [31:0] p;
        rst_i     = 1'b1;
        start_i   = 1'b0;
        pattern_i = '0;
        for (int i = 0; i < N; i++) corrupt[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        // Full-grant sweep: exact latency and literal bank contents.
        start_sweep(32'hA5A5_0000);
        wait_done(200, n);
        chk("done_latency", n, RB ? 34 : 17);
        chk("mem3_literal", mem[3], 32'hA5A5_0003);
        chk("mem15_literal", mem[15], 32'hA5A5_000F);
        check_sweep(32'hA5A5_0000, 1'b0, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", done, 1);

        // Random 50% grant stalls.
        rand_gnt = 1'b1;
        p = $urandom;
        start_sweep(p);
        wait_done(2000, n);
        check_sweep(p, 1'b0, 32'h0, 0);

        // Corrupted read responses at words 3 and 9.
        corrupt[3] = 1'b1;
        corrupt[9] = 1'b1;
        p = $urandom;
        start_sweep(p);
        wait_done(2000, n);
        check_sweep(p, RB, RB ? BASE + 32'h0C : 32'h0, RB ? 2 : 0);
        corrupt[3] = 1'b0;
        corrupt[9] = 1'b0;

        // start_i mid-sweep must be ignored.
        p = $urandom;
        start_sweep(p);
        n = 0;
        while (mk < (RB ? N + 3 : 5) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_mid_sweep", mk >= (RB ? N + 3 : 5), 1);
        start_i   = 1'b1;
        pattern_i = ~p;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_after_ignored_start", busy, 1);
        wait_done(2000, n);
        check_sweep(p, 1'b0, 32'h0, 0);

        // Asynchronous reset mid-WRITE at idx 5, then a clean restart.
        rand_gnt = 1'b0;
        repeat (2) @(posedge clk);
        start_sweep(32'h1234_5678);
        repeat (5) @(posedge clk);
        #3;
        chk("handshakes_before_rst", mk, 5);
        rst_i = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        p = $urandom;
        start_sweep(p);
        chk("restart_add", bus.add, BASE);
        chk("restart_data", bus.data, p);
        wait_done(200, n);
        chk("restart_latency", n, RB ? 34 : 17);
        check_sweep(p, 1'b0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
